// File: rtl/mb_sync_pkg.sv
// mb_sync_pkg: shared FSM state encoding and default parameters for mb_sync_rx.
`timescale 1ns/1ps
package mb_sync_pkg;
  localparam int NB_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;
  typedef enum logic [1:0] {IDLE, WAIT_SLOT, ACK} state_t;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: SYNC_STAGES-deep flop chain bringing a single asynchronous bit into the i_clock domain.
`timescale 1ns/1ps
module bit_sync
  import mb_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
  assign o_q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/mb_sync_rx.sv
// mb_sync_rx: four-phase request/acknowledge receiver feeding a valid/ready output register.
// Define MB_SYNC_RX_PARITY_EN to add even-parity checking (i_parity in, sticky o_parity_err out).
`timescale 1ns/1ps
module mb_sync_rx
  import mb_sync_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_req,
  input  logic [NB-1:0] i_data,
  output logic          o_ack,
  output logic [NB-1:0] o_data,
  output logic          o_valid,
`ifdef MB_SYNC_RX_PARITY_EN
  input  logic          i_parity,
  output logic          o_parity_err,
`endif
  input  logic          i_ready
);
  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          valid_q, valid_d;
  logic [NB-1:0] data_q, data_d;
  logic          req_s, free, take, bad;
  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_d      (i_req),
    .o_q      (req_s)
  );
`ifdef MB_SYNC_RX_PARITY_EN
  logic perr_q, perr_d;
  assign bad = (^i_data) ^ i_parity;
  assign perr_d = perr_q | (take & bad);
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) perr_q <= 1'b0;
    else perr_q <= perr_d;
  assign o_parity_err = perr_q;
`else
  assign bad = 1'b0;
`endif
  // A corrupted word is acknowledged but never presented as valid data.
  always_comb begin
    free    = !valid_q || i_ready;
    take    = state_q != ACK && req_s && free;
    state_d = state_q == ACK ? (req_s ? ACK : IDLE) : !req_s ? IDLE : free ? ACK : WAIT_SLOT;
    ack_d   = state_d == ACK;
    valid_d = (take && !bad) || (valid_q && !i_ready);
    data_d  = take && !bad ? i_data : data_q;
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  assign o_ack   = ack_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
endmodule

// File: tb/tb_mb_sync_rx.sv
// tb_mb_sync_rx: directed self-checking bench for mb_sync_rx (NB=8, SYNC_STAGES=2).
`timescale 1ns/1ps
module tb_mb_sync_rx;
  logic       i_clock = 1'b0;
  logic       src_clk = 1'b0;
  logic       i_reset_n;
  logic       i_req;
  logic [7:0] i_data;
  logic       i_parity;
  logic       i_ready;
  logic       o_ack;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  int checks = 0;
  int passed = 0;

  mb_sync_rx #(.NB(8), .SYNC_STAGES(2)) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_req       (i_req),
    .i_data      (i_data),
    .o_ack       (o_ack),
    .o_data      (o_data),
    .o_valid     (o_valid),
`ifdef MB_SYNC_RX_PARITY_EN
    .i_parity    (i_parity),
    .o_parity_err(o_parity_err),
`endif
    .i_ready     (i_ready)
  );
`ifndef MB_SYNC_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

  always #2 i_clock = ~i_clock;
  always #5 src_clk = ~src_clk;

  task automatic edges(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic test_reset;
    i_reset_n = 1'b0; i_req = 1'b1; i_data = 8'h3C; i_parity = ^8'h3C; i_ready = 1'b0;
    edges(3);
    checks++; if (o_ack !== 1'b0) $display("FAIL rst_ack got=%b exp=0", o_ack); else passed++;
    checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", o_valid); else passed++;
    checks++; if (o_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", o_data); else passed++;
    i_reset_n = 1'b1;
    edges(2);
    checks++; if (o_ack !== 1'b0) $display("FAIL rst_early_ack got=%b exp=0", o_ack); else passed++;
    checks++; if (o_valid !== 1'b0) $display("FAIL rst_early_valid got=%b exp=0", o_valid); else passed++;
    edges(1);
    checks++; if (o_ack !== 1'b1) $display("FAIL rst_rel_ack got=%b exp=1", o_ack); else passed++;
    checks++; if (o_valid !== 1'b1) $display("FAIL rst_rel_valid got=%b exp=1", o_valid); else passed++;
    checks++; if (o_data !== 8'h3C) $display("FAIL rst_rel_data got=%h exp=3c", o_data); else passed++;
    i_ready = 1'b1; i_req = 1'b0;
    edges(3);
    checks++; if (o_ack !== 1'b0) $display("FAIL rst_done_ack got=%b exp=0", o_ack); else passed++;
    checks++; if (o_valid !== 1'b0) $display("FAIL rst_done_valid got=%b exp=0", o_valid); else passed++;
  endtask

  task automatic test_latency;
    i_ready = 1'b1; i_data = 8'hA5; i_parity = ^8'hA5; i_req = 1'b1;
    edges(2);
    checks++; if (o_valid !== 1'b0) $display("FAIL lat_early_valid got=%b exp=0", o_valid); else passed++;
    edges(1);
    checks++; if (o_valid !== 1'b1) $display("FAIL lat_valid got=%b exp=1", o_valid); else passed++;
    checks++; if (o_data !== 8'hA5) $display("FAIL lat_data got=%h exp=a5", o_data); else passed++;
    checks++; if (o_ack !== 1'b1) $display("FAIL lat_ack got=%b exp=1", o_ack); else passed++;
    edges(1);
    checks++; if (o_valid !== 1'b0) $display("FAIL lat_xfer_valid got=%b exp=0", o_valid); else passed++;
    checks++; if (o_data !== 8'hA5) $display("FAIL lat_hold_data got=%h exp=a5", o_data); else passed++;
    i_req = 1'b0;
    edges(2);
    checks++; if (o_ack !== 1'b1) $display("FAIL lat_ack_hold got=%b exp=1", o_ack); else passed++;
    edges(1);
    checks++; if (o_ack !== 1'b0) $display("FAIL lat_ack_fall got=%b exp=0", o_ack); else passed++;
  endtask

  task automatic test_wait_slot;
    i_ready = 1'b0; i_data = 8'h11; i_parity = ^8'h11; i_req = 1'b1;
    edges(3);
    checks++; if (o_data !== 8'h11) $display("FAIL ws_first_data got=%h exp=11", o_data); else passed++;
    i_req = 1'b0;
    edges(3);
    checks++; if (o_ack !== 1'b0) $display("FAIL ws_first_ack got=%b exp=0", o_ack); else passed++;
    i_data = 8'h22; i_parity = ^8'h22; i_req = 1'b1;
    edges(7);
    checks++; if (o_ack !== 1'b0) $display("FAIL ws_wait_ack got=%b exp=0", o_ack); else passed++;
    checks++; if (o_valid !== 1'b1) $display("FAIL ws_wait_valid got=%b exp=1", o_valid); else passed++;
    checks++; if (o_data !== 8'h11) $display("FAIL ws_wait_data got=%h exp=11", o_data); else passed++;
    i_ready = 1'b1;
    edges(1);
    checks++; if (o_data !== 8'h22) $display("FAIL ws_swap_data got=%h exp=22", o_data); else passed++;
    checks++; if (o_valid !== 1'b1) $display("FAIL ws_swap_valid got=%b exp=1", o_valid); else passed++;
    checks++; if (o_ack !== 1'b1) $display("FAIL ws_swap_ack got=%b exp=1", o_ack); else passed++;
    i_ready = 1'b0; i_req = 1'b0;
    edges(3);
    checks++; if (o_ack !== 1'b0) $display("FAIL ws_end_ack got=%b exp=0", o_ack); else passed++;
    checks++; if (o_valid !== 1'b1) $display("FAIL ws_end_valid got=%b exp=1", o_valid); else passed++;
    i_ready = 1'b1;
    edges(1);
    checks++; if (o_valid !== 1'b0) $display("FAIL ws_drain_valid got=%b exp=0", o_valid); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit src_done = 0;
    bit src_to = 0;
    int cyc = 0;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'($urandom));
    fork
      begin
        for (int w = 0; w < 16 && !src_to; w++) begin
          int t = 0;
          @(posedge src_clk);
          i_data = exp_q[w]; i_parity = ^exp_q[w]; i_req = 1'b1;
          while (o_ack !== 1'b1 && t < 200) begin @(posedge src_clk); t++; end
          if (t >= 200) src_to = 1;
          i_req = 1'b0;
          t = 0;
          while (o_ack !== 1'b0 && t < 200) begin @(posedge src_clk); t++; end
          if (t >= 200) src_to = 1;
        end
        src_done = 1;
      end
      begin
        while (!(src_done && got_q.size() >= 16) && cyc < 5000) begin
          @(negedge i_clock);
          cyc++;
          i_ready = 1'($urandom_range(0, 1));
          if (o_valid && i_ready) got_q.push_back(o_data);
        end
      end
    join
    checks++; if (src_to !== 1'b0) $display("FAIL b2b_src_timeout got=%b exp=0", src_to); else passed++;
    checks++; if (got_q.size() != 16) $display("FAIL b2b_count got=%0d exp=16", got_q.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] g;
      g = i < got_q.size() ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_q[i]) $display("FAIL b2b_word%0d got=%h exp=%h", i, g, exp_q[i]); else passed++;
    end
    i_ready = 1'b1;
    edges(8);
    checks++; if (o_valid !== 1'b0) $display("FAIL b2b_no_dup got=%b exp=0", o_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    i_ready = 1'b0; i_data = 8'h5A; i_parity = ^8'h5A; i_req = 1'b1;
    edges(4);
    checks++; if (o_ack !== 1'b1) $display("FAIL rm_in_ack got=%b exp=1", o_ack); else passed++;
    i_reset_n = 1'b0;
    #1;
    checks++; if (o_ack !== 1'b0) $display("FAIL rm_async_ack got=%b exp=0", o_ack); else passed++;
    checks++; if (o_valid !== 1'b0) $display("FAIL rm_async_valid got=%b exp=0", o_valid); else passed++;
    edges(1);
    i_reset_n = 1'b1;
    edges(2);
    checks++; if (o_ack !== 1'b0) $display("FAIL rm_early_ack got=%b exp=0", o_ack); else passed++;
    edges(1);
    checks++; if (o_ack !== 1'b1) $display("FAIL rm_new_ack got=%b exp=1", o_ack); else passed++;
    checks++; if (o_data !== 8'h5A) $display("FAIL rm_new_data got=%h exp=5a", o_data); else passed++;
    i_req = 1'b0; i_ready = 1'b1;
    edges(3);
    checks++; if (o_ack !== 1'b0) $display("FAIL rm_end_ack got=%b exp=0", o_ack); else passed++;
    checks++; if (o_valid !== 1'b0) $display("FAIL rm_end_valid got=%b exp=0", o_valid); else passed++;
  endtask

`ifdef MB_SYNC_RX_PARITY_EN
  task automatic test_parity;
    checks++; if (o_parity_err !== 1'b0) $display("FAIL par_init got=%b exp=0", o_parity_err); else passed++;
    i_ready = 1'b0; i_data = 8'h01; i_parity = 1'b0; i_req = 1'b1;
    edges(3);
    checks++; if (o_ack !== 1'b1) $display("FAIL par_ack got=%b exp=1", o_ack); else passed++;
    checks++; if (o_valid !== 1'b0) $display("FAIL par_valid got=%b exp=0", o_valid); else passed++;
    checks++; if (o_parity_err !== 1'b1) $display("FAIL par_err got=%b exp=1", o_parity_err); else passed++;
    i_req = 1'b0;
    edges(3);
    checks++; if (o_ack !== 1'b0) $display("FAIL par_ack_fall got=%b exp=0", o_ack); else passed++;
    i_data = 8'h03; i_parity = 1'b0; i_req = 1'b1;
    edges(3);
    checks++; if (o_valid !== 1'b1) $display("FAIL par_good_valid got=%b exp=1", o_valid); else passed++;
    checks++; if (o_parity_err !== 1'b1) $display("FAIL par_sticky got=%b exp=1", o_parity_err); else passed++;
    i_req = 1'b0; i_ready = 1'b1;
    edges(3);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_latency;
    test_wait_slot;
    test_back_to_back;
    test_reset_mid;
`ifdef MB_SYNC_RX_PARITY_EN
    test_parity;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
